// File: rtl/tlb_cam.sv
// Fully-associative joint TLB: I/D translation ports, probe, indexed read and write.
// Latency: lookup, probe and read results are registered, valid one cycle after request.
// No backpressure: every request is accepted; optional TLB_PAGEMASK_EN enables variable pages.
module tlb_cam #(
  parameter int INDEX_W = 5,
  parameter int PFN_W   = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         asid,
  input  logic               i_req,
  input  logic [19:0]        i_vpn,
  input  logic               d_req,
  input  logic [19:0]        d_vpn,
  input  logic               d_store,
  output logic               i_rvalid,
  output logic               i_hit,
  output logic [PFN_W-1:0]   i_pfn,
  output logic [2:0]         i_c,
  output logic               i_v,
  output logic               i_refill,
  output logic               i_invalid,
  output logic               d_rvalid,
  output logic               d_hit,
  output logic [PFN_W-1:0]   d_pfn,
  output logic [2:0]         d_c,
  output logic               d_v,
  output logic               d_d,
  output logic               d_refill,
  output logic               d_invalid,
  output logic               d_modified,
  input  logic               p_req,
  input  logic [18:0]        p_vpn2,
  input  logic [7:0]         p_asid,
  output logic               p_rvalid,
  output logic               p_miss,
  output logic [INDEX_W-1:0] p_index,
  input  logic [INDEX_W-1:0] r_index,
  output logic [89:0]        r_entry,
  input  logic               w_en,
  input  logic [INDEX_W-1:0] w_index,
  input  logic [18:0]        w_vpn2,
  input  logic [7:0]         w_asid,
  input  logic [11:0]        w_mask,
  input  logic               w_g,
  input  logic [PFN_W-1:0]   w_pfn0,
  input  logic [PFN_W-1:0]   w_pfn1,
  input  logic [4:0]         w_flags0,
  input  logic [4:0]         w_flags1
);

  localparam int NUM_ENTRIES = 1 << INDEX_W;

  typedef struct packed {
    logic [18:0]      vpn2;
    logic [7:0]       asid;
`ifdef TLB_PAGEMASK_EN
    logic [11:0]      mask;
`endif
    logic             g;
    logic [PFN_W-1:0] pfn0;
    logic [2:0]       c0;
    logic             d0;
    logic             v0;
    logic [PFN_W-1:0] pfn1;
    logic [2:0]       c1;
    logic             d1;
    logic             v1;
  } entry_t;

  typedef struct packed {
    logic             hit;
    logic [PFN_W-1:0] pfn;
    logic [2:0]       c;
    logic             d;
    logic             v;
  } xlat_t;

  entry_t                  tlb [NUM_ENTRIES];
  entry_t                  w_entry;
  logic [18:0]             care [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  i_match, d_match, p_match;
  logic [INDEX_W-1:0]      i_idx, d_idx, p_idx;
  xlat_t                   ix, dx;

`ifndef TLB_PAGEMASK_EN
  // 4 KB-only build: the page mask input has no effect on state.
  logic unused_w_mask;
  assign unused_w_mask = ^w_mask;
`endif

  // Lowest set bit of a match vector; 0 when nothing matches.
  function automatic logic [INDEX_W-1:0] first_hit(input logic [NUM_ENTRIES-1:0] m);
    logic [INDEX_W-1:0] idx;
    idx = '0;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--)
      if (m[k]) idx = INDEX_W'(k);
    return idx;
  endfunction

  // Pick the even/odd half and splice the in-page VPN bits into the frame number.
  function automatic xlat_t xlat(input logic hit, input entry_t e, input logic [19:0] vpn);
    xlat_t            r;
    logic             odd;
    logic [PFN_W-1:0] sel;
`ifdef TLB_PAGEMASK_EN
    logic [4:0]       n;
    logic [PFN_W-1:0] low;
    n = '0;
    for (int b = 0; b < 12; b++) n = n + 5'(e.mask[b]);
    odd = vpn[n];
`else
    odd = vpn[0];
`endif
    sel = odd ? e.pfn1 : e.pfn0;
`ifdef TLB_PAGEMASK_EN
    low = (PFN_W'(1) << n) - PFN_W'(1);
    sel = (sel & ~low) | (PFN_W'(vpn) & low);
`endif
    r.hit = hit;
    r.pfn = sel;
    r.c   = odd ? e.c1 : e.c0;
    r.d   = odd ? e.d1 : e.d0;
    r.v   = odd ? e.v1 : e.v0;
    if (!hit) r = '0;
    return r;
  endfunction

  // Software-visible entry layout with PFNs normalised to 20 bits.
  function automatic logic [89:0] pack_entry(input entry_t e);
`ifdef TLB_PAGEMASK_EN
    return {e.vpn2, e.asid, e.mask, e.g, 20'(e.pfn0), e.c0, e.d0, e.v0,
            20'(e.pfn1), e.c1, e.d1, e.v1};
`else
    return {e.vpn2, e.asid, 12'h000, e.g, 20'(e.pfn0), e.c0, e.d0, e.v0,
            20'(e.pfn1), e.c1, e.d1, e.v1};
`endif
  endfunction

  // Compare every entry against the three lookup keys in parallel.
  always_comb begin
    i_match = '0;
    d_match = '0;
    p_match = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
`ifdef TLB_PAGEMASK_EN
      care[k] = ~{7'b0, tlb[k].mask};
`else
      care[k] = '1;
`endif
      i_match[k] = (((tlb[k].vpn2 ^ i_vpn[19:1]) & care[k]) == 19'b0) &&
                   (tlb[k].g || (tlb[k].asid == asid));
      d_match[k] = (((tlb[k].vpn2 ^ d_vpn[19:1]) & care[k]) == 19'b0) &&
                   (tlb[k].g || (tlb[k].asid == asid));
      p_match[k] = (((tlb[k].vpn2 ^ p_vpn2) & care[k]) == 19'b0) &&
                   (tlb[k].g || (tlb[k].asid == p_asid));
    end
  end

  assign i_idx = first_hit(i_match);
  assign d_idx = first_hit(d_match);
  assign p_idx = first_hit(p_match);
  assign ix    = xlat(|i_match, tlb[i_idx], i_vpn);
  assign dx    = xlat(|d_match, tlb[d_idx], d_vpn);

  // Assemble the entry image presented on the write port.
  always_comb begin
    w_entry      = '0;
    w_entry.vpn2 = w_vpn2;
    w_entry.asid = w_asid;
`ifdef TLB_PAGEMASK_EN
    w_entry.mask = w_mask;
`endif
    w_entry.g    = w_g;
    w_entry.pfn0 = w_pfn0;
    w_entry.pfn1 = w_pfn1;
    {w_entry.c0, w_entry.d0, w_entry.v0} = w_flags0;
    {w_entry.c1, w_entry.d1, w_entry.v1} = w_flags1;
  end

  // Entry storage; same-cycle readers see the pre-write contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_ENTRIES; k++) tlb[k] <= '0;
    end else if (w_en) begin
      tlb[w_index] <= w_entry;
    end
  end

  // Result registers: updated only on a request, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rvalid <= 1'b0; i_hit <= 1'b0; i_pfn <= '0; i_c <= '0; i_v <= 1'b0;
      i_refill <= 1'b0; i_invalid <= 1'b0;
      d_rvalid <= 1'b0; d_hit <= 1'b0; d_pfn <= '0; d_c <= '0; d_v <= 1'b0; d_d <= 1'b0;
      d_refill <= 1'b0; d_invalid <= 1'b0; d_modified <= 1'b0;
      p_rvalid <= 1'b0; p_miss <= 1'b0; p_index <= '0;
      r_entry  <= '0;
    end else begin
      i_rvalid <= i_req;
      d_rvalid <= d_req;
      p_rvalid <= p_req;
      r_entry  <= pack_entry(tlb[r_index]);
      if (i_req) begin
        i_hit     <= ix.hit;
        i_pfn     <= ix.pfn;
        i_c       <= ix.c;
        i_v       <= ix.v;
        i_refill  <= !ix.hit;
        i_invalid <= ix.hit && !ix.v;
      end
      if (d_req) begin
        d_hit      <= dx.hit;
        d_pfn      <= dx.pfn;
        d_c        <= dx.c;
        d_v        <= dx.v;
        d_d        <= dx.d;
        d_refill   <= !dx.hit;
        d_invalid  <= dx.hit && !dx.v;
        d_modified <= dx.hit && dx.v && d_store && !dx.d;
      end
      if (p_req) begin
        p_miss  <= ~|p_match;
        p_index <= p_idx;
      end
    end
  end

endmodule

// File: tb/tb_tlb_cam.sv
// Self-checking bench for tlb_cam: directed sequences, a d-port vector table,
// and randomized traffic against a page-arithmetic reference model.
module tb_tlb_cam;
  localparam int IW = 5;
  localparam int PW = 20;
  localparam int N  = 1 << IW;

  logic clk, reset;
  logic [7:0] asid;
  logic i_req, d_req, d_store, p_req, w_en, w_g;
  logic [19:0] i_vpn, d_vpn;
  logic i_rvalid, i_hit, i_v, i_refill, i_invalid;
  logic [PW-1:0] i_pfn, d_pfn, w_pfn0, w_pfn1;
  logic [2:0] i_c, d_c;
  logic d_rvalid, d_hit, d_v, d_d, d_refill, d_invalid, d_modified;
  logic [18:0] p_vpn2, w_vpn2;
  logic [7:0] p_asid, w_asid;
  logic p_rvalid, p_miss;
  logic [IW-1:0] p_index, r_index, w_index;
  logic [89:0] r_entry;
  logic [11:0] w_mask;
  logic [4:0] w_flags0, w_flags1;

  tlb_cam #(.INDEX_W(IW), .PFN_W(PW)) dut (
    .clk(clk), .reset(reset), .asid(asid),
    .i_req(i_req), .i_vpn(i_vpn), .d_req(d_req), .d_vpn(d_vpn), .d_store(d_store),
    .i_rvalid(i_rvalid), .i_hit(i_hit), .i_pfn(i_pfn), .i_c(i_c), .i_v(i_v),
    .i_refill(i_refill), .i_invalid(i_invalid),
    .d_rvalid(d_rvalid), .d_hit(d_hit), .d_pfn(d_pfn), .d_c(d_c), .d_v(d_v), .d_d(d_d),
    .d_refill(d_refill), .d_invalid(d_invalid), .d_modified(d_modified),
    .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid),
    .p_rvalid(p_rvalid), .p_miss(p_miss), .p_index(p_index),
    .r_index(r_index), .r_entry(r_entry),
    .w_en(w_en), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_mask(w_mask),
    .w_g(w_g), .w_pfn0(w_pfn0), .w_pfn1(w_pfn1), .w_flags0(w_flags0), .w_flags1(w_flags1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per entry, flags as {C,D,V}.
  logic [18:0] m_vpn2 [N];
  logic [7:0]  m_asid [N];
  logic [11:0] m_mask [N];
  logic        m_g    [N];
  logic [19:0] m_pfn0 [N];
  logic [19:0] m_pfn1 [N];
  logic [4:0]  m_f0   [N];
  logic [4:0]  m_f1   [N];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [19:0] vpn;
    logic [7:0]  asid;
    logic        store;
    logic        hit;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        v;
    logic        d;
    logic        refill;
    logic        invalid;
    logic        modified;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [89:0] act, input logic [89:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_vpn2[k] = '0; m_asid[k] = '0; m_mask[k] = '0; m_g[k] = 1'b0;
      m_pfn0[k] = '0; m_pfn1[k] = '0; m_f0[k] = '0; m_f1[k] = '0;
    end
  endtask

  task automatic drive_write(input int idx, input logic [18:0] vpn2, input logic [7:0] a,
                             input logic [11:0] mask, input logic g,
                             input logic [19:0] pfn0, input logic [4:0] f0,
                             input logic [19:0] pfn1, input logic [4:0] f1);
    w_en = 1'b1; w_index = IW'(idx); w_vpn2 = vpn2; w_asid = a; w_mask = mask; w_g = g;
    w_pfn0 = pfn0; w_flags0 = f0; w_pfn1 = pfn1; w_flags1 = f1;
  endtask

  // Called after the edge that performed the write.
  task automatic commit_write();
    int k;
    k = int'(w_index);
    m_vpn2[k] = w_vpn2; m_asid[k] = w_asid; m_g[k] = w_g;
`ifdef TLB_PAGEMASK_EN
    m_mask[k] = w_mask;
`else
    m_mask[k] = 12'h000;
`endif
    m_pfn0[k] = w_pfn0; m_pfn1[k] = w_pfn1; m_f0[k] = w_flags0; m_f1[k] = w_flags1;
    w_en = 1'b0;
  endtask

  task automatic do_write(input int idx, input logic [18:0] vpn2, input logic [7:0] a,
                          input logic [11:0] mask, input logic g,
                          input logic [19:0] pfn0, input logic [4:0] f0,
                          input logic [19:0] pfn1, input logic [4:0] f1);
    drive_write(idx, vpn2, a, mask, g, pfn0, f0, pfn1, f1);
    step();
    commit_write();
  endtask

  // A page of 2^(n+12) bytes per half: compare page numbers, splice in-page bits.
  function automatic void ref_lookup(input logic [19:0] vpn, input logic [7:0] a,
                                     output logic hit, output logic [IW-1:0] idx,
                                     output logic [19:0] pfn, output logic [4:0] fl);
    int n, v, base;
    hit = 1'b0; idx = '0; pfn = '0; fl = '0;
    v = int'(vpn);
    for (int k = 0; k < N; k++) begin
      n = $countones(m_mask[k]);
      if (!hit && (((v >> 1) >> n) == (int'(m_vpn2[k]) >> n)) &&
          (m_g[k] || m_asid[k] == a)) begin
        hit  = 1'b1;
        idx  = IW'(k);
        base = ((v >> n) & 1) == 1 ? int'(m_pfn1[k]) : int'(m_pfn0[k]);
        fl   = ((v >> n) & 1) == 1 ? m_f1[k] : m_f0[k];
        pfn  = 20'(((base >> n) << n) + (v % (1 << n)));
      end
    end
  endfunction

  function automatic logic [89:0] ref_entry(input int k);
    return {m_vpn2[k], m_asid[k], m_mask[k], m_g[k], m_pfn0[k], m_f0[k], m_pfn1[k], m_f1[k]};
  endfunction

  function automatic vec_t mk(input logic [19:0] vpn, input logic [7:0] a, input logic st,
                              input logic hit, input logic [19:0] pfn, input logic [2:0] c,
                              input logic v, input logic d, input logic rf,
                              input logic inv, input logic md);
    vec_t r;
    r.vpn = vpn; r.asid = a; r.store = st; r.hit = hit; r.pfn = pfn; r.c = c; r.v = v;
    r.d = d; r.refill = rf; r.invalid = inv; r.modified = md;
    return r;
  endfunction

  logic        e_ih, e_iref, e_iinv, e_dh, e_dref, e_dinv, e_dmod, e_pm;
  logic [19:0] e_ipfn, e_dpfn;
  logic [4:0]  e_ifl, e_dfl;
  logic [IW-1:0] e_pi;
  logic        rh, rstore, ri_req, rd_req, rp_req;
  logic [IW-1:0] ridx;
  logic [19:0] rpfn;
  logic [4:0]  rfl;
  logic [89:0] e_rent;

  initial begin
    reset = 1'b1; asid = '0; i_req = 1'b0; i_vpn = '0; d_req = 1'b0; d_vpn = '0;
    d_store = 1'b0; p_req = 1'b0; p_vpn2 = '0; p_asid = '0; r_index = '0;
    w_en = 1'b0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_mask = '0; w_g = 1'b0;
    w_pfn0 = '0; w_pfn1 = '0; w_flags0 = '0; w_flags1 = '0;
    model_clear();
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_i_rvalid", 90'(i_rvalid), 90'(0));
    chk("rst_d_rvalid", 90'(d_rvalid), 90'(0));
    chk("rst_p_rvalid", 90'(p_rvalid), 90'(0));
    chk("rst_flags", 90'({i_hit, d_hit, i_refill, d_refill, p_miss, p_index}), 90'(0));
    chk("rst_r_entry", r_entry, 90'(0));

    // Miss on an empty TLB; result then holds with no request.
    d_req = 1'b1; d_vpn = 20'h00400; step(); d_req = 1'b0;
    chk("miss_rvalid", 90'(d_rvalid), 90'(1));
    chk("miss_hit", 90'(d_hit), 90'(0));
    chk("miss_refill", 90'(d_refill), 90'(1));
    step();
    chk("miss_rvalid_drop", 90'(d_rvalid), 90'(0));
    chk("miss_refill_hold", 90'(d_refill), 90'(1));

    // Store to a clean, valid odd page.
    do_write(3, 19'h00200, 8'd5, 12'h000, 1'b0, 20'h1A000, 5'b01111, 20'h1B000, 5'b01101);
    asid = 8'd5; d_vpn = 20'h00401; d_store = 1'b1; d_req = 1'b1; r_index = 3;
    step(); d_req = 1'b0;
    chk("st_hit", 90'(d_hit), 90'(1));
    chk("st_pfn", 90'(d_pfn), 90'(20'h1B000));
    chk("st_c", 90'(d_c), 90'(3));
    chk("st_modified", 90'(d_modified), 90'(1));
    chk("st_r_entry", r_entry,
        {19'h00200, 8'd5, 12'h000, 1'b0, 20'h1A000, 5'b01111, 20'h1B000, 5'b01101});

    asid = 8'd6; d_req = 1'b1; step(); d_req = 1'b0;
    chk("asid_miss", 90'({d_hit, d_refill}), 90'(2'b01));
    do_write(3, 19'h00200, 8'd5, 12'h000, 1'b1, 20'h1A000, 5'b01111, 20'h1B000, 5'b01101);
    d_req = 1'b1; step(); d_req = 1'b0;
    chk("global_hit", 90'({d_hit, d_pfn}), {1'b1, 20'h1B000});

    // Write and lookup/read of the same entry in one cycle.
    drive_write(3, 19'h00200, 8'd5, 12'h000, 1'b1, 20'h1A000, 5'b01111, 20'h1C000, 5'b01101);
    d_req = 1'b1;
    step();
    commit_write();
    chk("coll_old_pfn", 90'(d_pfn), 90'(20'h1B000));
    chk("coll_old_rent", r_entry,
        {19'h00200, 8'd5, 12'h000, 1'b1, 20'h1A000, 5'b01111, 20'h1B000, 5'b01101});
    step(); d_req = 1'b0;
    chk("coll_new_pfn", 90'(d_pfn), 90'(20'h1C000));
    chk("coll_new_rent", r_entry, ref_entry(3));

    // Duplicate VPN2: probe reports the lowest index.
    do_write(2, 19'h12345, 8'd7, 12'h000, 1'b0, 20'h22222, 5'b10001, 20'h33333, 5'b00000);
    do_write(9, 19'h12345, 8'd7, 12'h000, 1'b0, 20'h99999, 5'b11111, 20'h99999, 5'b11111);
    p_req = 1'b1; p_vpn2 = 19'h12345; p_asid = 8'd7; step();
    chk("probe_dup", 90'({p_rvalid, p_miss, p_index}), 90'({1'b1, 1'b0, 5'd2}));
    p_vpn2 = 19'h54321; step(); p_req = 1'b0;
    chk("probe_absent", 90'({p_miss, p_index}), 90'({1'b1, 5'd0}));
    step();
    chk("probe_drop", 90'({p_rvalid, p_miss}), 90'(2'b01));

    // 16 KB page: VA[14] selects the odd half.
    do_write(5, 19'h00200, 8'd0, 12'h003, 1'b0, 20'h00000, 5'b00000, 20'h30000, 5'b00001);
    asid = 8'd0; i_req = 1'b1; i_vpn = 20'h00407; step(); i_req = 1'b0;
`ifdef TLB_PAGEMASK_EN
    chk("mask_i_hit", 90'({i_rvalid, i_hit, i_pfn, i_v}), {1'b1, 1'b1, 20'h30003, 1'b1});
`else
    chk("mask_i_hit", 90'({i_rvalid, i_hit, i_refill}), 90'(3'b101));
`endif

    // D-port vector table.
    tbl.push_back(mk(20'h00400, 8'd9, 1'b0, 1'b1, 20'h1A000, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(20'h00401, 8'd9, 1'b1, 1'b1, 20'h1C000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(20'h00401, 8'd9, 1'b0, 1'b1, 20'h1C000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(20'h2468A, 8'd7, 1'b1, 1'b1, 20'h22222, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(20'h2468B, 8'd7, 1'b0, 1'b1, 20'h33333, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(20'h2468B, 8'd7, 1'b1, 1'b1, 20'h33333, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(20'h2468A, 8'd8, 1'b1, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef TLB_PAGEMASK_EN
    tbl.push_back(mk(20'h00407, 8'd0, 1'b1, 1'b1, 20'h30003, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(20'h00403, 8'd0, 1'b0, 1'b1, 20'h00003, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
`else
    tbl.push_back(mk(20'h00407, 8'd0, 1'b1, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(20'h00403, 8'd0, 1'b0, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      d_vpn = tbl[i].vpn; asid = tbl[i].asid; d_store = tbl[i].store; d_req = 1'b1;
      step(); d_req = 1'b0;
      chk($sformatf("tbl%0d_flags", i), 90'({d_hit, d_refill, d_invalid, d_modified}),
          90'({tbl[i].hit, tbl[i].refill, tbl[i].invalid, tbl[i].modified}));
      if (tbl[i].hit)
        chk($sformatf("tbl%0d_xlat", i), 90'({d_pfn, d_c, d_v, d_d}),
            90'({tbl[i].pfn, tbl[i].c, tbl[i].v, tbl[i].d}));
    end

    // Reset while an I lookup is in flight.
    i_req = 1'b1; i_vpn = 20'h00400; asid = 8'd0; r_index = 3; reset = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0; reset = 1'b0;
    model_clear();
    chk("rmid_rvalid0", 90'(i_rvalid), 90'(0));
    step();
    chk("rmid_rvalid1", 90'(i_rvalid), 90'(0));
    chk("rmid_flags", 90'({i_hit, i_refill, i_invalid, d_hit, d_refill, d_invalid,
                           d_modified, p_miss, p_index}), 90'(0));
    chk("rmid_r_entry", r_entry, 90'(0));
    p_req = 1'b1; p_vpn2 = 19'h00200; p_asid = 8'd5; step(); p_req = 1'b0;
    chk("rmid_cleared", 90'({p_miss, p_index}), 90'({1'b1, 5'd0}));

    // Randomized traffic against the model.
    e_ih = 0; e_iref = 0; e_iinv = 0; e_ipfn = 0; e_ifl = 0;
    e_dh = 0; e_dref = 0; e_dinv = 0; e_dmod = 0; e_dpfn = 0; e_dfl = 0;
    e_pm = 1; e_pi = 0;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 2) == 0)
        drive_write($urandom_range(0, N - 1), 19'($urandom_range(0, 15)),
                    8'($urandom_range(0, 3)), 12'((1 << (2 * $urandom_range(0, 6))) - 1),
                    $urandom_range(0, 3) == 0, 20'($urandom), 5'($urandom),
                    20'($urandom), 5'($urandom));
      ri_req = 1'($urandom); rd_req = 1'($urandom); rp_req = 1'($urandom);
      rstore = 1'($urandom);
      i_req = ri_req; d_req = rd_req; p_req = rp_req; d_store = rstore;
      i_vpn = 20'($urandom_range(0, 31)); d_vpn = 20'($urandom_range(0, 31));
      p_vpn2 = 19'($urandom_range(0, 15)); asid = 8'($urandom_range(0, 3));
      p_asid = 8'($urandom_range(0, 3)); r_index = IW'($urandom_range(0, N - 1));
      e_rent = ref_entry(int'(r_index));
      if (ri_req) begin
        ref_lookup(i_vpn, asid, rh, ridx, rpfn, rfl);
        e_ih = rh; e_ipfn = rpfn; e_ifl = rfl; e_iref = !rh; e_iinv = rh && !rfl[0];
      end
      if (rd_req) begin
        ref_lookup(d_vpn, asid, rh, ridx, rpfn, rfl);
        e_dh = rh; e_dpfn = rpfn; e_dfl = rfl; e_dref = !rh; e_dinv = rh && !rfl[0];
        e_dmod = rh && rfl[0] && rstore && !rfl[1];
      end
      if (rp_req) begin
        ref_lookup({p_vpn2, 1'b0}, p_asid, rh, ridx, rpfn, rfl);
        e_pm = !rh; e_pi = rh ? ridx : '0;
      end
      step();
      if (w_en) commit_write();
      chk("rnd_rvalid", 90'({i_rvalid, d_rvalid, p_rvalid}), 90'({ri_req, rd_req, rp_req}));
      chk("rnd_i_flags", 90'({i_hit, i_refill, i_invalid}), 90'({e_ih, e_iref, e_iinv}));
      if (e_ih)
        chk("rnd_i_xlat", 90'({i_pfn, i_c, i_v}), 90'({e_ipfn, e_ifl[4:2], e_ifl[0]}));
      chk("rnd_d_flags", 90'({d_hit, d_refill, d_invalid, d_modified}),
          90'({e_dh, e_dref, e_dinv, e_dmod}));
      if (e_dh)
        chk("rnd_d_xlat", 90'({d_pfn, d_c, d_d, d_v}), 90'({e_dpfn, e_dfl}));
      chk("rnd_probe", 90'({p_miss, p_index}), 90'({e_pm, e_pi}));
      chk("rnd_r_entry", r_entry, e_rent);
    end
    i_req = 1'b0; d_req = 1'b0; p_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tlb_cam.md
# tlb_cam

Parametrised, fully-associative MIPS-style joint TLB with two independent translation ports (instruction and data), plus probe, indexed-read and indexed-write ports for the TLBP/TLBR/TLBWI/TLBWR instructions. It sits between the address-generation stages and the cache/AXI front end. Every lookup and probe result is registered, so results appear one cycle after the request. Variable page size is optional.

## Interface
- INDEX_W, 5, entry index width; NUM_ENTRIES = 1<<INDEX_W
- PFN_W, 20, physical frame number width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all entries and output registers
- asid  in  8  current EntryHi.ASID, shared by the I and D ports
- i_req / d_req  in  1  lookup request, one per port
- i_vpn / d_vpn  in  20  VA[31:12]
- d_store  in  1  data access is a store
- i_rvalid / d_rvalid  out  1  one-cycle pulse: result registers updated
- i_hit / d_hit  out  1  registered match
- i_pfn / d_pfn  out  PFN_W  translated frame number
- i_c / d_c  out  3  cache attribute
- i_v / d_v  out  1  valid flag of the selected half
- d_d  out  1  dirty flag of the selected half
- d_refill, d_invalid, d_modified  out  1  registered exception flags
- i_refill, i_invalid  out  1  registered exception flags
- p_req  in  1; p_vpn2  in  19; p_asid  in  8  probe request
- p_rvalid  out  1; p_miss  out  1; p_index  out  INDEX_W  probe result
- r_index  in  INDEX_W; r_entry  out  90  registered entry at r_index, packed {VPN2,ASID,PageMask,G,PFN0,C0,D0,V0,PFN1,C1,D1,V1}; PFN fields zero-extended or truncated to 20 bits
- w_en  in  1; w_index  in  INDEX_W; w_vpn2  in  19; w_asid  in  8; w_mask  in  12; w_g  in  1; w_pfn0/w_pfn1  in  PFN_W; w_flags0/w_flags1  in  5 ({C,D,V})

## Operation
- Storage: NUM_ENTRIES entries of {VPN2, ASID, MASK, G, PFN0, C0, D0, V0, PFN1, C1, D1, V1}.
- Match for entry k: ((VPN2_k ^ vpn[19:1]) & ~{7'b0,MASK_k}) == 0, and (G_k or ASID_k == asid).
- Multiple matches: the lowest index wins. Software must avoid multiple matches; the result is still deterministic.
- Odd/even select bit: VA[12+n], where n = popcount(MASK_k). Legal masks are 0x000, 0x003, 0x00F, 0x03F, 0x0FF, 0x3FF, 0xFFF. Other mask values are stored as written; translation with them is unspecified.
- pfn out: PFN_sel with its low n bits replaced by vpn[n-1:0].
- I-port flags:
  - i_refill = !hit
  - i_invalid = hit & !v
- D-port flags:
  - d_refill = !hit
  - d_invalid = hit & !v
  - d_modified = hit & v & d_store & !d
- Probe: same match rule on {p_vpn2, p_asid}. p_miss = no match. p_index = lowest matching index, or 0 on a miss.
- Write: when w_en is high, entry[w_index] takes all w_* fields at the rising edge.
- Read: r_entry is registered from entry[r_index] every cycle, so it reflects the entry one cycle after r_index is applied.

## Timing
- Lookup or probe requested in cycle N: results registered at the N→N+1 edge, and *_rvalid is high for cycle N+1 only.
- Result registers hold their value until the next request on the same port. With no request they do not change.
- Write in cycle N, colliding with a lookup, probe or read of the same entry in cycle N: the lookup, probe or read sees the old contents. The new contents are visible to requests issued in N+1 onward.
- I, D and probe requests in the same cycle are fully independent; there are no stalls and no ready signals.
- Reset:
  - All entries go to zero, so V0 = V1 = 0 and G = 0.
  - All outputs go to 0: *_rvalid = 0, *_hit = 0, p_miss = 0, p_index = 0, r_entry = 0, and all flags = 0.
- Reset asserted mid-request: the in-flight result is discarded and no rvalid pulse follows deassertion.

## Configuration
- TLB_PAGEMASK_EN defined:
  - MASK is stored and applied as described.
  - Page sizes from 4 KB to 16 MB.
- TLB_PAGEMASK_EN undefined:
  - w_mask is ignored and MASK reads as 0 in r_entry.
  - The odd/even select bit is always VA[12] and pfn = PFN_sel (4 KB pages only).
  - No popcount or mask logic is synthesised.

## Test plan
- Reset, then d_req with d_vpn=0x00400 → cycle+1: d_rvalid=1, d_hit=0, d_refill=1.
- Write idx 3: vpn2=0x00200, asid=5, G=0, PFN0=0x1A000 flags0=0b01111, PFN1=0x1B000 flags1=0b01101. Then d_req d_vpn=0x00401, asid=5, d_store=1 → d_hit=1, d_pfn=0x1B000, d_c=3, d_modified=1.
- Same entry, asid=6 → miss. Rewrite the entry with G=1 → hit with asid=6. Write and lookup of that entry in the same cycle → the lookup returns the old result; a request in the next cycle returns the new one.
- Duplicate vpn2 in idx 2 and idx 9, then p_req → p_miss=0, p_index=2. Probe of an absent vpn2 → p_miss=1, p_index=0.
- With TLB_PAGEMASK_EN: mask=0x003, vpn2=0x00200, PFN1=0x30000 V1=1; i_vpn=0x00407 → i_hit=1 (VA[14]=1 selects odd), i_pfn=0x30003. Without the macro, the same vpn gives i_hit=0.
- Assert reset while i_req is in flight → no i_rvalid pulse; r_entry and all flags read 0.
